// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the memory-stage controller.
//   state_t  : sequencer states (IDLE, W1 = second word, W2 = third word)
//   sp_src_t : stack-pointer update encodings from EX/MEM
//   op_t     : operand fields captured at the start of a multi-word access
package mem_pkg;
   localparam int          ADDR_W_DEF   = 20;
   localparam logic [19:0] SP_RESET_DEF = 20'hFFFFF;
   localparam int          FLAGS_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      W1   = 2'd1,
      W2   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SP_HOLD = 2'b00,
      SP_POP  = 2'b01,
      SP_PUSH = 2'b10,
      SP_RSVD = 2'b11
   } sp_src_t;

   typedef struct packed {
      logic               write;
      logic               read;
      logic               stack;
      sp_src_t            sp_mode;
      logic               pc_op;
      logic               flg_op;
      logic               two;
      logic [15:0]        base;
      logic [31:0]        wdata;
      logic [FLAGS_W-1:0] flags;
   } op_t;
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: bundle of EX/MEM operand fields, data-memory bus,
// port I/O and MEM/WB results around the memory-stage controller.
//   slave  : the controller (consumes EX/MEM + dm_rdata, drives the rest)
//   master : the surrounding pipeline / memory
interface mem_stage_ctrl_if #(parameter int ADDR_W = mem_pkg::ADDR_W_DEF);
   logic              stall_in;
   logic              mem_read_in;
   logic              mem_write_in;
   logic              mem_type_in;
   logic              mem_addr_src_in;
   logic              mem_data_src_in;
   logic [1:0]        SP_src_in;
   logic              INT_in;
   logic              PC_push_pop_in;
   logic              flags_push_pop_in;
   logic              port_write_in;
   logic              port_read_in;
   logic [3:0]        PORT_in;
   logic [15:0]       Rsrc_val_in;
   logic [15:0]       Rdst_val_in;
   logic [31:0]       PC_in;
   logic [3:0]        flags_in;
   logic [15:0]       in_port;
   logic [15:0]       dm_rdata;
   logic [ADDR_W-1:0] dm_addr;
   logic [15:0]       dm_wdata;
   logic              dm_we;
   logic [31:0]       load_data;
   logic              load_valid;
   logic [31:0]       pc_pop;
   logic              pc_pop_valid;
   logic [3:0]        flags_pop;
   logic              flags_pop_valid;
   logic [15:0]       out_port;
   logic [3:0]        out_port_sel;
   logic              stall_out;
   logic [ADDR_W-1:0] sp;

   modport slave (
      input  stall_in, mem_read_in, mem_write_in, mem_type_in, mem_addr_src_in,
             mem_data_src_in, SP_src_in, INT_in, PC_push_pop_in, flags_push_pop_in,
             port_write_in, port_read_in, PORT_in, Rsrc_val_in, Rdst_val_in,
             PC_in, flags_in, in_port, dm_rdata,
      output dm_addr, dm_wdata, dm_we, load_data, load_valid, pc_pop, pc_pop_valid,
             flags_pop, flags_pop_valid, out_port, out_port_sel, stall_out, sp
   );

   modport master (
      output stall_in, mem_read_in, mem_write_in, mem_type_in, mem_addr_src_in,
             mem_data_src_in, SP_src_in, INT_in, PC_push_pop_in, flags_push_pop_in,
             port_write_in, port_read_in, PORT_in, Rsrc_val_in, Rdst_val_in,
             PC_in, flags_in, in_port, dm_rdata,
      input  dm_addr, dm_wdata, dm_we, load_data, load_valid, pc_pop, pc_pop_valid,
             flags_pop, flags_pop_valid, out_port, out_port_sel, stall_out, sp
   );
endinterface

// File: rtl/sp_unit.sv
// sp_unit: stack-pointer register. Adds a signed delta when enabled;
// arithmetic wraps modulo 2^ADDR_W.
//   clk, reset : clock, synchronous active-high reset (sp -> SP_RESET)
//   en_i       : apply delta this cycle
//   delta_i    : signed step (-1 push, +1 pop)
//   sp_o       : current stack pointer
module sp_unit
   import mem_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEF)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en_i,
   input  logic signed [2:0]   delta_i,
   output logic [ADDR_W-1:0]   sp_o
);
   logic [ADDR_W-1:0] sp_q, sp_d;

   always_comb begin
      sp_d = sp_q;
      if (en_i) sp_d = sp_q + {{(ADDR_W-3){delta_i[2]}}, delta_i};
   end

   always_ff @(posedge clk) begin
      if (reset) sp_q <= SP_RESET;
      else       sp_q <= sp_d;
   end

   assign sp_o = sp_q;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller. Sequences 1..3 word data-memory
// accesses (loads/stores, PC push/pop, INT/RTI), drives the output port,
// owns the stack pointer and stalls upstream during multi-word accesses.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_stage_ctrl_if.slave (EX/MEM fields, dm bus, results)
module mem_stage_ctrl
   import mem_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEF)
) (
   input  logic           clk,
   input  logic           reset,
   mem_stage_ctrl_if.slave bus
);
   state_t            state_q, state_d;
   op_t               op_q, op_d, dec, cur;
   logic [15:0]       cap0_q, cap0_d, cap1_q, cap1_d;
   logic [15:0]       out_port_q, out_port_d;
   logic [3:0]        out_sel_q, out_sel_d;
   logic [1:0]        k;
   logic              go, mem_op, last, rev, port_in, port_wr, sp_en;
   logic              load_v, pc_v, flg_v;
   logic signed [2:0] sp_delta;
   logic [ADDR_W-1:0] sp, addr;
   logic [15:0]       wdata;
   logic [31:0]       word32;

   // Decode of the live EX/MEM word; INT overrides every other field.
   always_comb begin
      dec         = '0;
      dec.write   = bus.INT_in | bus.mem_write_in;
      dec.read    = ~bus.INT_in & bus.mem_read_in & ~bus.mem_write_in;
      dec.stack   = bus.INT_in | bus.mem_addr_src_in;
      dec.sp_mode = bus.INT_in ? SP_PUSH :
                    (sp_src_t'(bus.SP_src_in) == SP_RSVD) ? SP_HOLD : sp_src_t'(bus.SP_src_in);
      dec.pc_op   = bus.INT_in | bus.PC_push_pop_in;
      dec.flg_op  = bus.INT_in | bus.flags_push_pop_in;
      dec.two     = dec.pc_op | dec.flg_op | bus.mem_type_in;
      dec.base    = bus.Rsrc_val_in;
      dec.wdata   = (bus.INT_in | bus.mem_data_src_in) ? bus.PC_in : {16'b0, bus.Rdst_val_in};
      dec.flags   = bus.flags_in;
   end

   // Word sequencing: live fields in IDLE, captured copy in W1/W2.
   always_comb begin
      cur     = (state_q == IDLE) ? dec : op_q;
      k       = 2'(state_q);
      go      = ~reset & ~bus.stall_in;
      mem_op  = cur.write | cur.read;
      last    = cur.flg_op ? (k == 2'd2) : cur.two ? (k == 2'd1) : 1'b1;
      // Pops read the low half before the high half.
      rev     = cur.stack & (cur.sp_mode == SP_POP);
      port_in = (state_q == IDLE) & ~bus.INT_in & bus.port_read_in & ~mem_op;
      port_wr = go & (state_q == IDLE) & ~bus.INT_in & bus.port_write_in;

      // Push addresses the current SP, pop the slot above it; SP steps per word.
      if (cur.stack) begin
         case (cur.sp_mode)
            SP_PUSH: addr = sp;
            SP_POP:  addr = sp + ADDR_W'(1);
            default: addr = sp + ADDR_W'(k);
         endcase
      end else begin
         addr = {{(ADDR_W-16){1'b0}}, cur.base} + ADDR_W'(k);
      end

      case (k)
         2'd0:    wdata = cur.two ? cur.wdata[31:16] : cur.wdata[15:0];
         2'd1:    wdata = cur.wdata[15:0];
         default: wdata = {{(16-FLAGS_W){1'b0}}, cur.flags};
      endcase

      sp_en    = go & ((cur.sp_mode == SP_PUSH) | (cur.sp_mode == SP_POP));
      sp_delta = (cur.sp_mode == SP_PUSH) ? -3'sd1 : 3'sd1;

      if (!cur.two)       word32 = {16'b0, bus.dm_rdata};
      else if (cur.flg_op) word32 = {bus.dm_rdata, cap1_q};
      else if (rev)       word32 = {bus.dm_rdata, cap0_q};
      else                word32 = {cap0_q, bus.dm_rdata};

      load_v = go & last & ((cur.read & ~cur.pc_op) | port_in);
      pc_v   = go & last & cur.read & cur.pc_op;
      flg_v  = go & last & cur.read & cur.flg_op;

      state_d = state_q;
      if (go) begin
         case (state_q)
            IDLE:    if (mem_op && !last) state_d = W1;
            W1:      state_d = last ? IDLE : W2;
            default: state_d = IDLE;
         endcase
      end

      op_d       = (go && state_q == IDLE) ? dec : op_q;
      cap0_d     = (go && k == 2'd0) ? bus.dm_rdata : cap0_q;
      cap1_d     = (go && k == 2'd1) ? bus.dm_rdata : cap1_q;
      out_port_d = port_wr ? bus.Rdst_val_in : out_port_q;
      out_sel_d  = port_wr ? bus.PORT_in : out_sel_q;
   end

   sp_unit #(.ADDR_W(ADDR_W), .SP_RESET(SP_RESET)) u_sp (
      .clk     (clk),
      .reset   (reset),
      .en_i    (sp_en),
      .delta_i (sp_delta),
      .sp_o    (sp)
   );

   // Control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         out_port_q <= '0;
         out_sel_q  <= '0;
      end else begin
         state_q    <= state_d;
         out_port_q <= out_port_d;
         out_sel_q  <= out_sel_d;
      end
   end

   // Operand and read-capture registers.
   always_ff @(posedge clk) begin
      op_q   <= op_d;
      cap0_q <= cap0_d;
      cap1_q <= cap1_d;
   end

   assign bus.dm_addr         = addr;
   assign bus.dm_wdata        = wdata;
   assign bus.dm_we           = go & cur.write;
   assign bus.stall_out       = ~reset & mem_op & ~last;
   assign bus.load_valid      = load_v;
   assign bus.load_data       = load_v ? (port_in ? {16'b0, bus.in_port} : word32) : 32'b0;
   assign bus.pc_pop_valid    = pc_v;
   assign bus.pc_pop          = pc_v ? word32 : 32'b0;
   assign bus.flags_pop_valid = flg_v;
   assign bus.flags_pop       = flg_v ? cap0_q[3:0] : 4'b0;
   assign bus.out_port        = out_port_q;
   assign bus.out_port_sel    = out_sel_q;
   assign bus.sp              = sp;
endmodule
